// File: rtl/dram_req_arbiter.sv
// dram_req_arbiter: two-master round-robin front end for the DRAM controller.
// Port A (instruction fetch) is read-only, port B (data) is read/write. Only
// one controller transaction is outstanding at a time. Read data is captured
// when the controller drops busy and is returned with a one-cycle done pulse.
module dram_req_arbiter #(
  parameter int TIMEOUT_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  // port A: read-only master
  input  logic        i_a_req,
  input  logic [31:0] i_a_addr,
  input  logic [2:0]  i_a_ctrl,
  output logic        o_a_done,
  output logic [31:0] o_a_rdata,
  // port B: read/write master
  input  logic        i_b_req,
  input  logic        i_b_we,
  input  logic [31:0] i_b_addr,
  input  logic [31:0] i_b_wdata,
  input  logic [2:0]  i_b_ctrl,
  output logic        o_b_done,
  output logic [31:0] o_b_rdata,
  // controller user interface
  output logic        o_mem_rd_en,
  output logic        o_mem_wr_en,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [2:0]  o_mem_ctrl,
  input  logic        i_mem_busy,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_mem_calib,
  // status
  output logic        o_grant_b,
  output logic        o_timeout
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ISSUE     = 3'd1;
  localparam logic [2:0] S_WAIT_ACC  = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_RESP      = 3'd4;

  localparam logic [TIMEOUT_W-1:0] WD_ONE = {{(TIMEOUT_W-1){1'b0}}, 1'b1};
  localparam logic [TIMEOUT_W-1:0] WD_MAX = {TIMEOUT_W{1'b1}};

  logic [2:0]           state;
  logic [2:0]           state_nxt;
  logic                 grant_b;
  logic                 last_b;     // 1 when port B owned the last completed transaction
  logic [31:0]          addr_q;
  logic [31:0]          wdata_q;
  logic [2:0]           ctrl_q;
  logic                 we_q;
  logic [31:0]          a_rdata_q;
  logic [31:0]          b_rdata_q;
  logic [TIMEOUT_W-1:0] wd_cnt;
  logic                 timeout_q;

  logic                 can_grant;
  logic                 pick_b;
  logic                 in_wait;
  logic                 mem_complete;

  // Arbitration: new grants only with the controller calibrated and idle.
  // On a tie the port that did not win last time is picked.
  always_comb begin
    can_grant    = 1'b0;
    pick_b       = 1'b0;
    in_wait      = (state == S_WAIT_ACC) || (state == S_WAIT_DONE);
    mem_complete = (state == S_WAIT_DONE) && !i_mem_busy;
    if ((state == S_IDLE) && i_mem_calib && !i_mem_busy && (i_a_req || i_b_req)) begin
      can_grant = 1'b1;
      pick_b    = i_b_req && (!i_a_req || !last_b);
    end
  end

  // Next-state logic for the transaction FSM.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (can_grant) state_nxt = S_ISSUE;
      S_ISSUE:     state_nxt = S_WAIT_ACC;
      S_WAIT_ACC:  if (i_mem_busy) state_nxt = S_WAIT_DONE;
      S_WAIT_DONE: if (!i_mem_busy) state_nxt = S_RESP;
      S_RESP:      state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // State register; reset aborts any in-flight transaction silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Grant ownership and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_b <= 1'b0;
      last_b  <= 1'b0;
    end else begin
      if (can_grant) begin
        grant_b <= pick_b;
      end else if (state == S_RESP) begin
        grant_b <= 1'b0;
      end
      if (mem_complete) begin
        last_b <= grant_b;
      end
    end
  end

  // Latch the winner's request so the masters' lines may change after grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      ctrl_q  <= 3'd0;
      we_q    <= 1'b0;
    end else if (can_grant) begin
      if (pick_b) begin
        addr_q  <= i_b_addr;
        wdata_q <= i_b_wdata;
        ctrl_q  <= i_b_ctrl;
        we_q    <= i_b_we;
      end else begin
        addr_q  <= i_a_addr;
        wdata_q <= 32'd0;
        ctrl_q  <= i_a_ctrl;
        we_q    <= 1'b0;
      end
    end
  end

  // Capture controller data for the owner when busy falls (writes included).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_rdata_q <= 32'd0;
      b_rdata_q <= 32'd0;
    end else if (mem_complete) begin
      if (grant_b) begin
        b_rdata_q <= i_mem_rdata;
      end else begin
        a_rdata_q <= i_mem_rdata;
      end
    end
  end

  // Watchdog: counts wait cycles, saturates, and leaves a sticky flag behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (can_grant) begin
        wd_cnt <= '0;
      end else if (in_wait && (wd_cnt != WD_MAX)) begin
        wd_cnt <= wd_cnt + WD_ONE;
        if (wd_cnt == (WD_MAX - WD_ONE)) begin
          timeout_q <= 1'b1;
        end
      end
    end
  end

  // Enables are decoded from ISSUE so they can never last more than a cycle.
  assign o_mem_rd_en = (state == S_ISSUE) && !we_q;
  assign o_mem_wr_en = (state == S_ISSUE) && we_q;
  assign o_mem_addr  = addr_q;
  assign o_mem_wdata = wdata_q;
  assign o_mem_ctrl  = ctrl_q;

  assign o_a_done    = (state == S_RESP) && !grant_b;
  assign o_b_done    = (state == S_RESP) && grant_b;
  assign o_a_rdata   = a_rdata_q;
  assign o_b_rdata   = b_rdata_q;
  assign o_grant_b   = grant_b;
  assign o_timeout   = timeout_q;

endmodule

// File: tb/tb_dram_req_arbiter.sv
// Directed testbench for dram_req_arbiter with a small controller model.
module tb_dram_req_arbiter;

  localparam int TW = 4;
  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_req, b_req, b_we;
  logic [31:0] a_addr, b_addr, b_wdata;
  logic [2:0]  a_ctrl, b_ctrl;
  logic        a_done, b_done;
  logic [31:0] a_rdata, b_rdata;
  logic        mem_rd_en, mem_wr_en;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  mem_ctrl;
  logic        mem_busy, mem_calib;
  logic        grant_b, timeout;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  dram_req_arbiter #(.TIMEOUT_W(TW)) dut (
    .clk(clk), .rst(rst),
    .i_a_req(a_req), .i_a_addr(a_addr), .i_a_ctrl(a_ctrl),
    .o_a_done(a_done), .o_a_rdata(a_rdata),
    .i_b_req(b_req), .i_b_we(b_we), .i_b_addr(b_addr), .i_b_wdata(b_wdata),
    .i_b_ctrl(b_ctrl), .o_b_done(b_done), .o_b_rdata(b_rdata),
    .o_mem_rd_en(mem_rd_en), .o_mem_wr_en(mem_wr_en), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .o_mem_ctrl(mem_ctrl),
    .i_mem_busy(mem_busy), .i_mem_rdata(mem_rdata), .i_mem_calib(mem_calib),
    .o_grant_b(grant_b), .o_timeout(timeout)
  );

  // Controller model: busy rises the cycle after an enable and stays high for
  // busy_len cycles (or indefinitely while stuck); read data is fixed or
  // derived from the accepted address.
  int   busy_len;
  int   busy_cnt;
  logic stuck;
  logic fixed;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_busy  <= 1'b0;
      busy_cnt  <= 0;
      mem_rdata <= 32'd0;
    end else if (mem_rd_en || mem_wr_en) begin
      mem_busy  <= 1'b1;
      busy_cnt  <= busy_len;
      mem_rdata <= fixed ? 32'hDEAD_BEEF : (mem_addr ^ KEY);
    end else if (mem_busy && !stuck) begin
      if (busy_cnt <= 1) mem_busy <= 1'b0;
      busy_cnt <= busy_cnt - 1;
    end
  end

  // Monitor: samples pre-edge values of the DUT outputs on each rising edge.
  int          rd_cnt = 0, wr_cnt = 0, a_done_cnt = 0, b_done_cnt = 0, multi_cnt = 0;
  logic        en_prev = 1'b0;
  logic [31:0] last_addr = 32'd0, last_wdata = 32'd0;
  logic [2:0]  last_ctrl = 3'd0;
  always @(posedge clk) begin
    if (mem_rd_en) rd_cnt <= rd_cnt + 1;
    if (mem_wr_en) wr_cnt <= wr_cnt + 1;
    if (a_done) a_done_cnt <= a_done_cnt + 1;
    if (b_done) b_done_cnt <= b_done_cnt + 1;
    if ((mem_rd_en || mem_wr_en) && en_prev) multi_cnt <= multi_cnt + 1;
    en_prev <= mem_rd_en || mem_wr_en;
    if (mem_rd_en || mem_wr_en) begin
      last_addr  <= mem_addr;
      last_wdata <= mem_wdata;
      last_ctrl  <= mem_ctrl;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input bit want_b, input int max_cyc, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (want_b ? b_done : a_done) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_any_done(input int max_cyc, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (a_done || b_done) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_rd_en(input int max_cyc, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (mem_rd_en) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL global_time_limit observed=expired expected=finish");
    $fatal(1, "time limit");
  end

  initial begin
    bit seen;
    int s_rd, s_wr, s_ad, s_bd, s_multi;
    logic exp_b;

    rst = 1'b1; mem_calib = 1'b0;
    a_req = 1'b0; a_addr = 32'd0; a_ctrl = 3'd0;
    b_req = 1'b0; b_we = 1'b0; b_addr = 32'd0; b_wdata = 32'd0; b_ctrl = 3'd0;
    busy_len = 8; stuck = 1'b0; fixed = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_rd_en", mem_rd_en, 0);
    check("rst_wr_en", mem_wr_en, 0);
    check("rst_a_done", a_done, 0);
    check("rst_b_done", b_done, 0);
    check("rst_grant_b", grant_b, 0);
    check("rst_timeout", timeout, 0);
    check("rst_a_rdata", a_rdata, 0);
    check("rst_b_rdata", b_rdata, 0);
    check("rst_mem_addr", mem_addr, 0);
    rst = 1'b0;

    // calibration gating, then a single A read
    fixed = 1'b1;
    a_addr = 32'h8000_0010; a_ctrl = 3'b010; a_req = 1'b1;
    s_rd = rd_cnt; s_wr = wr_cnt; s_bd = b_done_cnt; s_multi = multi_cnt;
    repeat (20) @(negedge clk);
    check("calib_gate_rd", rd_cnt - s_rd, 0);
    mem_calib = 1'b1;
    wait_done(1'b0, 40, seen);
    check("a_read_done_seen", seen, 1);
    check("a_read_rdata", a_rdata, 32'hDEAD_BEEF);
    check("a_read_grant_b", grant_b, 0);
    check("a_read_rd_pulses", rd_cnt - s_rd, 1);
    check("a_read_wr_pulses", wr_cnt - s_wr, 0);
    check("a_read_en_one_cycle", multi_cnt - s_multi, 0);
    check("a_read_addr", last_addr, 32'h8000_0010);
    check("a_read_ctrl", last_ctrl, 3'b010);
    check("a_read_no_b_done", b_done_cnt - s_bd, 0);
    a_req = 1'b0;
    @(negedge clk);
    check("a_done_one_cycle", a_done, 0);
    fixed = 1'b0;

    // port B write
    s_rd = rd_cnt; s_wr = wr_cnt; s_ad = a_done_cnt; s_multi = multi_cnt;
    b_we = 1'b1; b_addr = 32'h8000_0003; b_wdata = 32'h1122_3344; b_ctrl = 3'b001;
    b_req = 1'b1;
    wait_done(1'b1, 40, seen);
    check("b_write_done_seen", seen, 1);
    check("b_write_grant_b", grant_b, 1);
    check("b_write_wr_pulses", wr_cnt - s_wr, 1);
    check("b_write_rd_pulses", rd_cnt - s_rd, 0);
    check("b_write_en_one_cycle", multi_cnt - s_multi, 0);
    check("b_write_addr", last_addr, 32'h8000_0003);
    check("b_write_wdata", last_wdata, 32'h1122_3344);
    check("b_write_ctrl", last_ctrl, 3'b001);
    check("b_write_no_a_done", a_done_cnt - s_ad, 0);
    b_req = 1'b0; b_we = 1'b0;

    // contention after reset: B, A, B, A
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    busy_len = 2;
    a_addr = 32'h0000_0100; a_ctrl = 3'b010;
    b_addr = 32'h0000_0200; b_ctrl = 3'b010;
    a_req = 1'b1; b_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_b = ((k % 2) == 0);
      wait_any_done(30, seen);
      check($sformatf("rr%0d_done_seen", k), seen, 1);
      check($sformatf("rr%0d_owner_b", k), b_done, exp_b);
      if (b_done) check($sformatf("rr%0d_b_rdata", k), b_rdata, 32'h0000_0200 ^ KEY);
      else        check($sformatf("rr%0d_a_rdata", k), a_rdata, 32'h0000_0100 ^ KEY);
    end
    a_req = 1'b0; b_req = 1'b0;

    // watchdog with the controller stuck busy
    @(negedge clk);
    stuck = 1'b1;
    a_addr = 32'h0000_0300; a_req = 1'b1;
    s_ad = a_done_cnt;
    wait_rd_en(20, seen);
    check("wd_issue_seen", seen, 1);
    repeat (15) @(negedge clk);
    check("wd_not_yet", timeout, 0);
    @(negedge clk);
    check("wd_set", timeout, 1);
    repeat (10) @(negedge clk);
    check("wd_sticky", timeout, 1);
    check("wd_no_done", a_done_cnt - s_ad, 0);
    stuck = 1'b0;
    wait_done(1'b0, 30, seen);
    check("wd_done_seen", seen, 1);
    check("wd_rdata", a_rdata, 32'h0000_0300 ^ KEY);
    check("wd_sticky_after", timeout, 1);
    a_req = 1'b0;

    // asynchronous reset while waiting for the controller
    @(negedge clk);
    busy_len = 8;
    a_addr = 32'h0000_0400; a_req = 1'b1;
    wait_rd_en(20, seen);
    check("ar_issue_seen", seen, 1);
    repeat (3) @(negedge clk);
    s_ad = a_done_cnt;
    #2 rst = 1'b1;
    #1;
    check("ar_rd_en", mem_rd_en, 0);
    check("ar_wr_en", mem_wr_en, 0);
    check("ar_a_done", a_done, 0);
    check("ar_grant_b", grant_b, 0);
    check("ar_timeout", timeout, 0);
    check("ar_a_rdata", a_rdata, 0);
    check("ar_mem_addr", mem_addr, 0);
    @(negedge clk);
    a_addr = 32'h0000_0500;
    @(negedge clk);
    rst = 1'b0;
    wait_done(1'b0, 40, seen);
    check("ar_fresh_done_seen", seen, 1);
    check("ar_fresh_rdata", a_rdata, 32'h0000_0500 ^ KEY);
    check("ar_no_abort_done", a_done_cnt - s_ad, 0);
    a_req = 1'b0;
    @(negedge clk);
    check("ar_fresh_done_count", a_done_cnt - s_ad, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
